// File: rtl/multiport_reg_file.sv
// Two-read / one-write register file with a pending-producer scoreboard and a
// self-clearing init sequence that zeroes one register per cycle.
module multiport_reg_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              pend1,
  output logic              pend2,
  input  logic              clr,
  output logic              init_busy
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic              ready, wr_ok, rsv_ok;

  assign ready  = (state_q == READY);
  assign wr_ok  = ready && wr_en  && !(ZERO_REG != 0 && wr_addr  == '0);
  assign rsv_ok = ready && rsv_en && !(ZERO_REG != 0 && rsv_addr == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    case (state_q)
      CLEAR: begin
        pend_d = '0;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH-1)) state_d = READY;
      end
      READY: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
          pend_d  = '0;
        end else begin
          // reserve applied last so a same-address new producer wins
          if (wr_ok)  pend_d[wr_addr]  = 1'b0;
          if (rsv_ok) pend_d[rsv_addr] = 1'b1;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Storage needs no reset: the clear sequence overwrites every entry before READY.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR)  regs_q[cnt_q]   <= '0;
    else if (wr_ok)        regs_q[wr_addr] <= wr_data;
  end

  function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] a);
    if (!ready || (ZERO_REG != 0 && a == '0)) return '0;
    if (BYPASS != 0 && wr_ok && wr_addr == a) return wr_data;
    return regs_q[a];
  endfunction

  assign rd_data1  = rd_port(rd_addr1);
  assign rd_data2  = rd_port(rd_addr2);
  assign pend1     = ready & pend_q[rd_addr1];
  assign pend2     = ready & pend_q[rd_addr2];
  assign init_busy = ~ready;

endmodule
